counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
- Parametrised multi-channel successor to the single ALU counter.
- NUM_CH independent WIDTH-bit counters behind one command port.
- Each channel runs in one of three modes:
  - manual count;
  - one-shot auto run;
  - periodic auto run.
- Adds:
  - a shared prescaler;
  - per-channel done flags;
  - an interrupt pulse on stop-value reach;
  - registered read-back.
- Sits beside the ALU; the control decoder drives the command port.

Parameters:
- WIDTH, 8, counter/start/stop/read width.
- NUM_CH, 4, number of channels (>=1).
- CH_W, 2, channel select width, >= clog2(NUM_CH), min 1.
- PRESCALE, 1, RUN-mode advance period in clk cycles (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous and active-high
- cmd_valid  in  1  command present this cycle
- cmd_op  in  3  opcode: 0 NOP, 1 SET_COUNT, 2 SET_ONESHOT, 3 SET_PERIODIC, 4 TRIGGER, 5 RESET, 6 STOP, 7 READ
- cmd_ch  in  CH_W  target channel; values >= NUM_CH make the command a no-op
- cmd_d0  in  WIDTH  start/count value
- cmd_d1  in  WIDTH  stop value
- rd_valid  out  1  read data valid
- rd_data  out  WIDTH  counter value of the channel read
- rd_status  out  4  {mode[1:0], periodic, done} of the channel read
- done_flags  out  NUM_CH  per-channel sticky done
- irq  out  1  one-cycle pulse on any channel reach

Behaviour:
- Reset (rst=1 at posedge), per channel:
  - mode=COUNT(00), cnt=start=stop=0, periodic=0, done=0, trigger history=0.
  - Prescaler=0; rd_valid=0, rd_data=0, rd_status=0, irq=0.
- Modes: COUNT=00, ARMED=01, RUN=10; 11 is unreachable and is treated as COUNT.
- SET_COUNT: cnt<=d0, start<=d0, stop<=d1, periodic<=0, done<=0, mode<=COUNT.
- SET_ONESHOT / SET_PERIODIC:
  - Same loads as SET_COUNT.
  - periodic<=0 for SET_ONESHOT, 1 for SET_PERIODIC; mode<=ARMED.
- TRIGGER is edge-qualified per channel:
  - It acts only if the previous cycle was not a valid TRIGGER to the same channel.
  - Holding TRIGGER for N cycles therefore acts once.
- TRIGGER effect by mode:
  - COUNT: cnt<=cnt+1.
  - ARMED: mode<=RUN, cnt unchanged.
  - RUN: cnt<=start, stays RUN.
- RESET: cnt<=start, done<=0, mode unchanged.
- STOP: RUN->ARMED, cnt held; no effect in the other modes.
- READ:
  - Next cycle: rd_valid=1, rd_data and rd_status show the channel's state sampled before this cycle's update.
  - rd_valid=0 on every other cycle; rd_data/rd_status hold their last value.
  - READ does not clear done.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 when prescaler==PRESCALE-1; with PRESCALE=1, tick=1 every cycle.
  - Free-running and shared by all channels.
- RUN advance on tick, only when no command targets the channel this cycle:
  - If stop!=0 and cnt==stop (reach): cnt<=start, done<=1, irq pulses next cycle. Periodic=0 goes to ARMED; periodic=1 stays RUN.
  - Otherwise cnt<=cnt+1.
  - Reach is evaluated only on tick.
- stop==0 means free-run: cnt wraps (2^WIDTH-1)->0 with no done and no irq.
- Arithmetic is modulo 2^WIDTH in every mode; COUNT-mode increment wraps silently.
- Priority: a command targeting a channel beats that channel's tick advance and reach in the same cycle. The reach is lost, not deferred.
- irq:
  - Registered OR of this cycle's reach events across all channels.
  - Simultaneous reaches on several channels give a single pulse; all of those done flags are set.
- Reset mid-run aborts all activity; irq issued the same cycle is suppressed.

Test Plan:
- Reset, then READ ch0 -> rd_valid=1 next cycle, rd_data=0, rd_status=4'b0000, irq=0.
- SET_COUNT ch1 d0=5, then TRIGGER held 3 cycles, TRIGGER again after a NOP cycle, READ ch1 -> rd_data=7.
- PRESCALE=1: SET_ONESHOT ch2 d0=2 d1=4, TRIGGER:
  - cnt 2,3,4, then reach: cnt=2, irq one pulse, done_flags[2]=1, mode=ARMED;
  - READ -> rd_status=4'b0101.
- SET_PERIODIC ch0 d0=0 d1=3, TRIGGER, run 12 cycles -> irq pulses every 4 cycles, mode stays RUN; RESET clears done_flags[0].
- PRESCALE=4, WIDTH=8: SET_PERIODIC ch3 d0=250 d1=0, TRIGGER -> cnt advances once per 4 clks, wraps 255->0, no irq.
- Collisions:
  - RESET issued on the reach tick -> cnt=start, no irq, done=0.
  - Same-cycle reach on ch0 and ch1 -> one irq pulse, both done bits set.

Source files
------------

// File: rtl/counter_bank_if.sv
// Command / read-back bus between the control decoder and counter_bank.
interface counter_bank_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [CH_W-1:0]   cmd_ch;
  logic [WIDTH-1:0]  cmd_d0;
  logic [WIDTH-1:0]  cmd_d1;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic [3:0]        rd_status;
  logic [NUM_CH-1:0] done_flags;
  logic              irq;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_d0, cmd_d1,
    input  rd_valid, rd_data, rd_status, done_flags, irq
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_d0, cmd_d1,
    output rd_valid, rd_data, rd_status, done_flags, irq
  );
endinterface

// File: rtl/counter_bank.sv
// Multi-channel counter bank: per-channel count/one-shot/periodic counters,
// shared prescaler, sticky done flags, reach interrupt and registered read-back.
package counter_bank_pkg;
  typedef enum logic [2:0] {
    OP_NOP          = 3'd0,
    OP_SET_COUNT    = 3'd1,
    OP_SET_ONESHOT  = 3'd2,
    OP_SET_PERIODIC = 3'd3,
    OP_TRIGGER      = 3'd4,
    OP_RESET        = 3'd5,
    OP_STOP         = 3'd6,
    OP_READ         = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    M_COUNT = 2'b00,
    M_ARMED = 2'b01,
    M_RUN   = 2'b10
  } mode_e;
endpackage

module counter_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             sel,
  input  op_e              op,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] cnt,
  output logic [3:0]       status,
  output logic             done,
  output logic             reach
);
  mode_e            mode_q, mode_n;
  logic [WIDTH-1:0] cnt_q, cnt_n, start_q, start_n, stop_q, stop_n;
  logic             per_q, per_n, done_q, done_n, trig_q, trig_now;

  assign trig_now = sel && (op == OP_TRIGGER);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= M_COUNT;
      cnt_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      mode_q  <= mode_n;
      cnt_q   <= cnt_n;
      start_q <= start_n;
      stop_q  <= stop_n;
      per_q   <= per_n;
      done_q  <= done_n;
      trig_q  <= trig_now;
    end
  end

  // A command to this channel pre-empts the tick; a reach landing on it is dropped.
  always_comb begin
    mode_n  = mode_q;
    cnt_n   = cnt_q;
    start_n = start_q;
    stop_n  = stop_q;
    per_n   = per_q;
    done_n  = done_q;
    reach   = 1'b0;
    if (sel) begin
      case (op)
        OP_SET_COUNT, OP_SET_ONESHOT, OP_SET_PERIODIC: begin
          cnt_n   = d0;
          start_n = d0;
          stop_n  = d1;
          done_n  = 1'b0;
          per_n   = (op == OP_SET_PERIODIC);
          mode_n  = (op == OP_SET_COUNT) ? M_COUNT : M_ARMED;
        end
        OP_TRIGGER: if (!trig_q) begin
          case (mode_q)
            M_ARMED: mode_n = M_RUN;
            M_RUN:   cnt_n  = start_q;
            default: cnt_n  = cnt_q + WIDTH'(1);
          endcase
        end
        OP_RESET: begin
          cnt_n  = start_q;
          done_n = 1'b0;
        end
        OP_STOP: if (mode_q == M_RUN) mode_n = M_ARMED;
        default: ;
      endcase
    end else if (tick && mode_q == M_RUN) begin
      if (stop_q != '0 && cnt_q == stop_q) begin
        reach  = 1'b1;
        cnt_n  = start_q;
        done_n = 1'b1;
        if (!per_q) mode_n = M_ARMED;
      end else begin
        cnt_n = cnt_q + WIDTH'(1);
      end
    end
  end

  assign cnt    = cnt_q;
  assign done   = done_q;
  assign status = {mode_q, per_q, done_q};
endmodule

module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int PRESCALE = 1
) (
  input  logic           clk,
  input  logic           rst,
  counter_bank_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]                  pre;
  logic                           tick;
  op_e                            op;
  logic [NUM_CH-1:0]              sel, reach, done;
  logic [NUM_CH-1:0][WIDTH-1:0]   cnt;
  logic [NUM_CH-1:0][3:0]         status;
  logic                           rd_fire, rd_valid_q, irq_q;
  logic [WIDTH-1:0]               rd_d, rd_data_q;
  logic [3:0]                     rd_s, rd_status_q;

  assign op   = op_e'(bus.cmd_op);
  assign tick = (pre == PW'(PRESCALE - 1));

  // Channel selects above NUM_CH-1 match no lane, so such commands fall through.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel[i] = bus.cmd_valid && (bus.cmd_ch == CH_W'(i));
    counter_ch #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .sel    (sel[i]),
      .op     (op),
      .d0     (bus.cmd_d0),
      .d1     (bus.cmd_d1),
      .cnt    (cnt[i]),
      .status (status[i]),
      .done   (done[i]),
      .reach  (reach[i])
    );
  end

  always_comb begin
    rd_d = '0;
    rd_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) begin
        rd_d = cnt[i];
        rd_s = status[i];
      end
    end
  end

  assign rd_fire = (op == OP_READ) && (|sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      irq_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_status_q <= '0;
    end else begin
      pre        <= tick ? '0 : pre + 1'b1;
      irq_q      <= |reach;
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q   <= rd_d;
        rd_status_q <= rd_s;
      end
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_status  = rd_status_q;
  assign bus.irq        = irq_q;
  assign bus.done_flags = done;
endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_counter_bank;
  localparam logic [2:0] NOP = 3'd0, SETC = 3'd1, SET1 = 3'd2, SETP = 3'd3,
                         TRIG = 3'd4, RSTC = 3'd5, STOP = 3'd6, READ = 3'd7;

  typedef struct packed { logic irq; logic [3:0] done; logic rd0; } cyc_exp_t;
  typedef struct packed { logic [7:0] data; logic [3:0] status; } rd_exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic chk0, fin;
  logic [3:0] dfa;
  int errors = 0;
  int checks = 0;

  cyc_exp_t ea[$], eb[$];
  rd_exp_t  qa[$], qb[$];

  always #5 clk = ~clk;

  counter_bank_if #(.WIDTH(8), .NUM_CH(4), .CH_W(2)) ifa ();
  counter_bank_if #(.WIDTH(8), .NUM_CH(4), .CH_W(2)) ifb ();

  counter_bank #(.WIDTH(8), .NUM_CH(4), .CH_W(2), .PRESCALE(1)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa.slave));
  counter_bank #(.WIDTH(8), .NUM_CH(4), .CH_W(2), .PRESCALE(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb.slave));

  // One clock with an optional command to A or B; queues per-cycle expectations.
  task automatic cyc(input bit v, input bit to_b, input logic [2:0] op,
                     input logic [1:0] ch, input logic [7:0] d0, input logic [7:0] d1,
                     input bit eirq);
    ifa.cmd_valid = v && !to_b;
    ifb.cmd_valid = v && to_b;
    ifa.cmd_op = op;  ifb.cmd_op = op;
    ifa.cmd_ch = ch;  ifb.cmd_ch = ch;
    ifa.cmd_d0 = d0;  ifb.cmd_d0 = d0;
    ifa.cmd_d1 = d1;  ifb.cmd_d1 = d1;
    ea.push_back(cyc_exp_t'{eirq, dfa, chk0});
    eb.push_back(cyc_exp_t'{1'b0, 4'b0000, chk0});
    @(negedge clk);
  endtask

  task automatic ca(input logic [2:0] op, input logic [1:0] ch,
                    input logic [7:0] d0 = 8'd0, input logic [7:0] d1 = 8'd0);
    cyc(1'b1, 1'b0, op, ch, d0, d1, 1'b0);
  endtask

  task automatic cb(input logic [2:0] op, input logic [1:0] ch,
                    input logic [7:0] d0 = 8'd0, input logic [7:0] d1 = 8'd0);
    cyc(1'b1, 1'b1, op, ch, d0, d1, 1'b0);
  endtask

  task automatic idle(input bit eirq = 1'b0);
    cyc(1'b0, 1'b0, NOP, 2'd0, 8'd0, 8'd0, eirq);
  endtask

  task automatic rda(input logic [1:0] ch, input logic [7:0] data, input logic [3:0] st);
    qa.push_back(rd_exp_t'{data, st});
    ca(READ, ch);
  endtask

  task automatic rdb(input logic [1:0] ch, input logic [7:0] data, input logic [3:0] st);
    qb.push_back(rd_exp_t'{data, st});
    cb(READ, ch);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations and compares whatever the DUTs present this cycle.
  always @(negedge clk) begin
    cyc_exp_t ce;
    rd_exp_t  re;
    if (ea.size() != 0) begin
      ce = ea.pop_front();
      chk("a_irq", int'(ifa.irq), int'(ce.irq));
      chk("a_done_flags", int'(ifa.done_flags), int'(ce.done));
      if (ce.rd0) begin
        chk("a_rst_rd_valid", int'(ifa.rd_valid), 0);
        chk("a_rst_rd_data", int'(ifa.rd_data), 0);
        chk("a_rst_rd_status", int'(ifa.rd_status), 0);
      end
    end
    if (eb.size() != 0) begin
      ce = eb.pop_front();
      chk("b_irq", int'(ifb.irq), int'(ce.irq));
      chk("b_done_flags", int'(ifb.done_flags), int'(ce.done));
    end
    if (ifa.rd_valid) begin
      if (qa.size() == 0) chk("a_rd_unexpected", 1, 0);
      else begin
        re = qa.pop_front();
        chk("a_rd_data", int'(ifa.rd_data), int'(re.data));
        chk("a_rd_status", int'(ifa.rd_status), int'(re.status));
      end
    end
    if (ifb.rd_valid) begin
      if (qb.size() == 0) chk("b_rd_unexpected", 1, 0);
      else begin
        re = qb.pop_front();
        chk("b_rd_data", int'(ifb.rd_data), int'(re.data));
        chk("b_rd_status", int'(ifb.rd_status), int'(re.status));
      end
    end
    if (fin) begin
      chk("a_rd_missing", qa.size(), 0);
      chk("b_rd_missing", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    fin = 1'b0; dfa = 4'b0000; chk0 = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    idle(); idle();
    rst_a = 1'b0; rst_b = 1'b0;
    idle();
    chk0 = 1'b0;

    // Reset state read-back
    rda(2'd0, 8'd0, 4'b0000);

    // Held TRIGGER acts once; a gap re-arms it
    ca(SETC, 2'd1, 8'd5, 8'd0);
    ca(TRIG, 2'd1); ca(TRIG, 2'd1); ca(TRIG, 2'd1);
    idle();
    ca(TRIG, 2'd1);
    rda(2'd1, 8'd7, 4'b0000);

    // COUNT-mode increment wraps
    ca(SETC, 2'd3, 8'd255, 8'd0);
    ca(TRIG, 2'd3);
    rda(2'd3, 8'd0, 4'b0000);

    // One-shot 2..4: reach on the third tick, back to ARMED at start
    ca(SET1, 2'd2, 8'd2, 8'd4);
    ca(TRIG, 2'd2);
    idle(); idle();
    dfa[2] = 1'b1;
    idle(1'b1);
    idle();
    rda(2'd2, 8'd2, 4'b0101);

    // Periodic 0..3: irq every 4 cycles, stays RUN
    ca(SETP, 2'd0, 8'd0, 8'd3);
    ca(TRIG, 2'd0);
    for (int k = 1; k <= 12; k++) begin
      if (k % 4 == 0) dfa[0] = 1'b1;
      idle(k % 4 == 0);
    end
    rda(2'd0, 8'd0, 4'b1011);
    dfa[0] = 1'b0;
    ca(RSTC, 2'd0);
    ca(STOP, 2'd0);
    rda(2'd0, 8'd0, 4'b0110);

    // RESET landing on the reach tick wins: no irq, no done
    ca(SET1, 2'd1, 8'd1, 8'd3);
    ca(TRIG, 2'd1);
    idle(); idle();
    ca(RSTC, 2'd1);
    ca(STOP, 2'd1);
    rda(2'd1, 8'd1, 4'b0100);

    // Simultaneous reach on ch0 and ch1: single pulse, both done
    ca(SET1, 2'd0, 8'd0, 8'd3);
    ca(SET1, 2'd1, 8'd0, 8'd2);
    ca(TRIG, 2'd0);
    ca(TRIG, 2'd1);
    idle(); idle();
    dfa[1:0] = 2'b11;
    idle(1'b1);
    idle();
    rda(2'd0, 8'd0, 4'b0101);
    rda(2'd1, 8'd0, 4'b0101);

    // PRESCALE=4 free-run from 250 wraps through 0 with no irq
    rst_b = 1'b1;
    idle();
    rst_b = 1'b0;
    cb(SETP, 2'd3, 8'd250, 8'd0);
    cb(TRIG, 2'd3);
    for (int k = 3; k <= 30; k++) begin
      if (k % 4 == 2) rdb(2'd3, 8'(250 + (k - 1) / 4), 4'b1010);
      else idle();
    end

    idle(); idle();
    fin = 1'b1;
  end
endmodule
